// File: rtl/cpu_multicycle.sv
// ============================================================================
// Module   : cpu_multicycle
// Purpose  : Multicycle RV32I core with req/ack instruction and data buses.
//            The FSM walks FETCH -> EXEC -> (MEM -> (WB)) -> FETCH. Any trap
//            (ecall/ebreak, illegal encoding, misaligned control-flow target,
//            misaligned data access) parks the core in HALT until reset.
// Ports    : clk, reset (sync, active-low)
//            imem_req/imem_addr/imem_ack/imem_rdata  - instruction fetch bus
//            dmem_req/dmem_addr/dmem_wdata/dmem_we/
//            dmem_ack/dmem_rdata                     - data bus
//            retire, halted, trap_cause              - status
//            cycle_cnt, instret_cnt                  - performance counters
// Config   : define CPU_MC_PERF_EN to build the 64-bit cycle/instret
//            counters; otherwise both counter outputs are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_multicycle #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_we,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        retire,
    output logic        halted,
    output logic [1:0]  trap_cause,
    output logic [63:0] cycle_cnt,
    output logic [63:0] instret_cnt
);

    localparam logic [2:0] c_st_fetch = 3'd0;
    localparam logic [2:0] c_st_exec  = 3'd1;
    localparam logic [2:0] c_st_mem   = 3'd2;
    localparam logic [2:0] c_st_wb    = 3'd3;
    localparam logic [2:0] c_st_halt  = 3'd4;

    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_reg    = 7'b0110011;
    localparam logic [6:0] c_op_fence  = 7'b0001111;
    localparam logic [6:0] c_op_system = 7'b1110011;

    localparam logic [1:0] c_cause_env   = 2'd0;
    localparam logic [1:0] c_cause_ill   = 2'd1;
    localparam logic [1:0] c_cause_jmp   = 2'd2;
    localparam logic [1:0] c_cause_data  = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic        r_imem_req;
    logic        r_dmem_req;
    logic [31:0] r_dmem_addr;
    logic [31:0] r_dmem_wdata;
    logic [3:0]  r_dmem_we;
    logic        r_retire;
    logic        r_halted;
    logic [1:0]  r_trap_cause;
    logic [31:0] r_load_data;
    logic [31:0] r_rf [0:31];

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [6:0]  w_opcode;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [31:0] w_rs1_val, w_rs2_val;

    assign w_opcode = r_ir[6:0];
    assign w_rd     = r_ir[11:7];
    assign w_funct3 = r_ir[14:12];
    assign w_rs1    = r_ir[19:15];
    assign w_rs2    = r_ir[24:20];
    assign w_funct7 = r_ir[31:25];

    assign w_imm_i = {{20{r_ir[31]}}, r_ir[31:20]};
    assign w_imm_s = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
    assign w_imm_b = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
    assign w_imm_u = {r_ir[31:12], 12'b0};
    assign w_imm_j = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};

    assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : r_rf[w_rs1];
    assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : r_rf[w_rs2];

    logic w_legal;
    logic w_env;

    // ecall and ebreak are the only SYSTEM encodings supported; CSR ops are illegal.
    assign w_env = (r_ir == 32'h0000_0073) || (r_ir == 32'h0010_0073);

    always_comb begin
        w_legal = 1'b0;
        case (w_opcode)
            c_op_lui, c_op_auipc, c_op_jal: w_legal = 1'b1;
            c_op_jalr:   w_legal = (w_funct3 == 3'b000);
            c_op_branch: w_legal = (w_funct3[2:1] != 2'b01);
            c_op_load:   w_legal = (w_funct3 != 3'b011) && (w_funct3[2:1] != 2'b11);
            c_op_store:  w_legal = !w_funct3[2] && (w_funct3 != 3'b011);
            c_op_imm: begin
                if (w_funct3 == 3'b001)
                    w_legal = (w_funct7 == 7'b0000000);
                else if (w_funct3 == 3'b101)
                    w_legal = (w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000);
                else
                    w_legal = 1'b1;
            end
            c_op_reg: w_legal = (w_funct7 == 7'b0000000) ||
                                ((w_funct7 == 7'b0100000) &&
                                 ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
            c_op_fence:  w_legal = (w_funct3 == 3'b000);
            c_op_system: w_legal = w_env;
            default:     w_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // ALU (register or I-type operand)
    // ------------------------------------------------------------------
    logic [31:0] w_alu_b;
    logic [31:0] w_alu_res;
    logic [4:0]  w_shamt;

    assign w_alu_b = (w_opcode == c_op_reg) ? w_rs2_val : w_imm_i;
    assign w_shamt = w_alu_b[4:0];

    always_comb begin
        w_alu_res = 32'd0;
        case (w_funct3)
            // ir[30] selects SUB only for register ops; for ADDI it is immediate data.
            3'b000: w_alu_res = ((w_opcode == c_op_reg) && r_ir[30]) ?
                                w_rs1_val - w_alu_b : w_rs1_val + w_alu_b;
            3'b001: w_alu_res = w_rs1_val << w_shamt;
            3'b010: w_alu_res = {31'd0, $signed(w_rs1_val) < $signed(w_alu_b)};
            3'b011: w_alu_res = {31'd0, w_rs1_val < w_alu_b};
            3'b100: w_alu_res = w_rs1_val ^ w_alu_b;
            3'b101: w_alu_res = r_ir[30] ? $unsigned($signed(w_rs1_val) >>> w_shamt)
                                         : w_rs1_val >> w_shamt;
            3'b110: w_alu_res = w_rs1_val | w_alu_b;
            default: w_alu_res = w_rs1_val & w_alu_b;
        endcase
    end

    // ------------------------------------------------------------------
    // Branch resolution and next PC
    // ------------------------------------------------------------------
    logic        w_br_cond;
    logic        w_take;
    logic [31:0] w_target;
    logic        w_target_bad;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_next_pc;

    always_comb begin
        w_br_cond = 1'b0;
        case (w_funct3)
            3'b000: w_br_cond = (w_rs1_val == w_rs2_val);
            3'b001: w_br_cond = (w_rs1_val != w_rs2_val);
            3'b100: w_br_cond = ($signed(w_rs1_val) <  $signed(w_rs2_val));
            3'b101: w_br_cond = ($signed(w_rs1_val) >= $signed(w_rs2_val));
            3'b110: w_br_cond = (w_rs1_val <  w_rs2_val);
            3'b111: w_br_cond = (w_rs1_val >= w_rs2_val);
            default: w_br_cond = 1'b0;
        endcase
    end

    assign w_take = (w_opcode == c_op_jal) || (w_opcode == c_op_jalr) ||
                    ((w_opcode == c_op_branch) && w_br_cond);
    assign w_target = (w_opcode == c_op_jalr) ? ((w_rs1_val + w_imm_i) & ~32'd1) :
                      (r_pc + ((w_opcode == c_op_jal) ? w_imm_j : w_imm_b));
    assign w_target_bad = w_take && (w_target[1:0] != 2'b00);
    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_next_pc    = w_take ? w_target : w_pc_plus4;

    // ------------------------------------------------------------------
    // Register write value for instructions completing in EXEC
    // ------------------------------------------------------------------
    logic [31:0] w_exec_wdata;
    logic        w_exec_writes;

    always_comb begin
        w_exec_wdata = w_alu_res;
        case (w_opcode)
            c_op_lui:             w_exec_wdata = w_imm_u;
            c_op_auipc:           w_exec_wdata = r_pc + w_imm_u;
            c_op_jal, c_op_jalr:  w_exec_wdata = w_pc_plus4;
            default:              w_exec_wdata = w_alu_res;
        endcase
    end

    assign w_exec_writes = (w_opcode == c_op_lui) || (w_opcode == c_op_auipc) ||
                           (w_opcode == c_op_jal) || (w_opcode == c_op_jalr) ||
                           (w_opcode == c_op_imm) || (w_opcode == c_op_reg);

    // ------------------------------------------------------------------
    // Load/store address, alignment, lanes
    // ------------------------------------------------------------------
    logic        w_is_store;
    logic        w_is_mem;
    logic [31:0] w_mem_addr;
    logic        w_mem_mis;
    logic [31:0] w_st_data;
    logic [3:0]  w_st_we;

    assign w_is_store = (w_opcode == c_op_store);
    assign w_is_mem   = w_is_store || (w_opcode == c_op_load);
    assign w_mem_addr = w_rs1_val + (w_is_store ? w_imm_s : w_imm_i);
    assign w_mem_mis  = ((w_funct3[1:0] == 2'b10) && (w_mem_addr[1:0] != 2'b00)) ||
                        ((w_funct3[1:0] == 2'b01) && w_mem_addr[0]);

    always_comb begin
        case (w_funct3[1:0])
            2'b00: begin
                w_st_data = {4{w_rs2_val[7:0]}};
                w_st_we   = 4'b0001 << w_mem_addr[1:0];
            end
            2'b01: begin
                w_st_data = {2{w_rs2_val[15:0]}};
                w_st_we   = w_mem_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_st_data = w_rs2_val;
                w_st_we   = 4'b1111;
            end
        endcase
    end

    // Load extraction from the word latched in MEM.
    logic [31:0] w_ld_shift;
    logic [31:0] w_load_val;

    assign w_ld_shift = r_load_data >> {r_dmem_addr[1:0], 3'b000};

    always_comb begin
        case (w_funct3)
            3'b000:  w_load_val = {{24{w_ld_shift[7]}},  w_ld_shift[7:0]};
            3'b001:  w_load_val = {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
            3'b100:  w_load_val = {24'd0, w_ld_shift[7:0]};
            3'b101:  w_load_val = {16'd0, w_ld_shift[15:0]};
            default: w_load_val = w_ld_shift;
        endcase
    end

    // EXEC completes in place only for legal, non-trapping, non-memory ops.
    logic w_exec_done;
    assign w_exec_done = (r_state == c_st_exec) && w_legal && !w_env &&
                         !w_target_bad && !w_is_mem;

    // ------------------------------------------------------------------
    // Main FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= c_st_fetch;
            r_pc         <= RESET_PC;
            r_ir         <= 32'd0;
            r_imem_req   <= 1'b0;
            r_dmem_req   <= 1'b0;
            r_dmem_addr  <= 32'd0;
            r_dmem_wdata <= 32'd0;
            r_dmem_we    <= 4'd0;
            r_retire     <= 1'b0;
            r_halted     <= 1'b0;
            r_trap_cause <= 2'd0;
            r_load_data  <= 32'd0;
        end else begin
            r_retire <= 1'b0;
            case (r_state)
                c_st_fetch: begin
                    // Only the first fetch after reset arrives here with req low;
                    // every other entry into FETCH raises req on the same edge.
                    if (!r_imem_req) begin
                        r_imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        r_ir       <= imem_rdata;
                        r_imem_req <= 1'b0;
                        r_state    <= c_st_exec;
                    end
                end
                c_st_exec: begin
                    if (!w_legal) begin
                        r_halted     <= 1'b1;
                        r_trap_cause <= c_cause_ill;
                        r_state      <= c_st_halt;
                    end else if (w_env) begin
                        r_halted     <= 1'b1;
                        r_trap_cause <= c_cause_env;
                        r_state      <= c_st_halt;
                    end else if (w_target_bad) begin
                        r_halted     <= 1'b1;
                        r_trap_cause <= c_cause_jmp;
                        r_state      <= c_st_halt;
                    end else if (w_is_mem) begin
                        if (w_mem_mis) begin
                            r_halted     <= 1'b1;
                            r_trap_cause <= c_cause_data;
                            r_state      <= c_st_halt;
                        end else begin
                            r_dmem_req   <= 1'b1;
                            r_dmem_addr  <= w_mem_addr;
                            r_dmem_wdata <= w_st_data;
                            r_dmem_we    <= w_is_store ? w_st_we : 4'd0;
                            r_state      <= c_st_mem;
                        end
                    end else begin
                        r_pc       <= w_next_pc;
                        r_retire   <= 1'b1;
                        r_imem_req <= 1'b1;
                        r_state    <= c_st_fetch;
                    end
                end
                c_st_mem: begin
                    if (r_dmem_req && dmem_ack) begin
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 4'd0;
                        if (w_is_store) begin
                            r_pc       <= w_pc_plus4;
                            r_retire   <= 1'b1;
                            r_imem_req <= 1'b1;
                            r_state    <= c_st_fetch;
                        end else begin
                            r_load_data <= dmem_rdata;
                            r_state     <= c_st_wb;
                        end
                    end
                end
                c_st_wb: begin
                    r_pc       <= w_pc_plus4;
                    r_retire   <= 1'b1;
                    r_imem_req <= 1'b1;
                    r_state    <= c_st_fetch;
                end
                c_st_halt: begin
                    r_state <= c_st_halt;
                end
                default: begin
                    r_halted     <= 1'b1;
                    r_trap_cause <= c_cause_ill;
                    r_state      <= c_st_halt;
                end
            endcase
        end
    end

    // Register file: contents survive reset, writes are blocked while in reset.
    logic        w_rf_we;
    logic [31:0] w_rf_wdata;

    assign w_rf_we    = (w_exec_done && w_exec_writes) || (r_state == c_st_wb);
    assign w_rf_wdata = (r_state == c_st_wb) ? w_load_val : w_exec_wdata;

    always_ff @(posedge clk) begin
        if (reset && w_rf_we && (w_rd != 5'd0)) begin
            r_rf[w_rd] <= w_rf_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef CPU_MC_PERF_EN
    logic [63:0] r_cycle_cnt;
    logic [63:0] r_instret_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cycle_cnt   <= 64'd0;
            r_instret_cnt <= 64'd0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 64'd1;
            if (r_retire) begin
                r_instret_cnt <= r_instret_cnt + 64'd1;
            end
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;
`else
    assign cycle_cnt   = 64'd0;
    assign instret_cnt = 64'd0;
`endif

    assign imem_req   = r_imem_req;
    assign imem_addr  = r_pc;
    assign dmem_req   = r_dmem_req;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wdata = r_dmem_wdata;
    assign dmem_we    = r_dmem_we;
    assign retire     = r_retire;
    assign halted     = r_halted;
    assign trap_cause = r_trap_cause;

endmodule

`default_nettype wire

// File: tb/tb_cpu_multicycle.sv
// ============================================================================
// Module   : tb_cpu_multicycle
// Purpose  : Self-checking bench for cpu_multicycle. Memory responders with
//            configurable wait states feed hand-assembled programs; a monitor
//            compares every data-bus access against a queue of expected
//            accesses, and the main sequence checks halt cause, PC and timing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_multicycle;

    localparam logic [31:0] c_reset_pc = 32'h0000_0100;
    localparam logic [31:0] c_ebreak   = 32'h0010_0073;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_we;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        retire;
    logic        halted;
    logic [1:0]  trap_cause;
    logic [63:0] cycle_cnt;
    logic [63:0] instret_cnt;

    cpu_multicycle #(.RESET_PC(c_reset_pc)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .retire(retire), .halted(halted), .trap_cause(trap_cause),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  we;
        int          len;   // expected req cycles including ack cycle; 0 = any
    } acc_t;

    logic [31:0] imem [0:255];
    logic [31:0] dmem [0:63];
    acc_t        exp_q[$];
    int          retire_log[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          rel_cyc = 0;
    int          n_acc = 0;
    int          imem_wait = 0;
    int          dmem_wait = 0;
    logic        manual = 1'b0;
    logic        manual_iack = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Memory responders: decide ack for the current cycle at each falling edge.
    initial begin
        int i_cnt = 0;
        int d_cnt = 0;
        imem_ack = 1'b0; imem_rdata = 32'd0;
        dmem_ack = 1'b0; dmem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (manual) begin
                imem_ack   = manual_iack;
                imem_rdata = 32'd0;
                i_cnt      = 0;
            end else if (imem_req) begin
                if (i_cnt >= imem_wait) begin
                    imem_ack   = 1'b1;
                    imem_rdata = imem[imem_addr[9:2]];
                    i_cnt      = 0;
                end else begin
                    imem_ack = 1'b0;
                    i_cnt    = i_cnt + 1;
                end
            end else begin
                imem_ack = 1'b0;
                i_cnt    = 0;
            end
            if (dmem_req) begin
                if (d_cnt >= dmem_wait) begin
                    dmem_ack = 1'b1;
                    d_cnt    = 0;
                    if (dmem_we != 4'd0) begin
                        for (int b = 0; b < 4; b++)
                            if (dmem_we[b]) dmem[dmem_addr[7:2]][8*b +: 8] = dmem_wdata[8*b +: 8];
                    end else begin
                        dmem_rdata = dmem[dmem_addr[7:2]];
                    end
                end else begin
                    dmem_ack = 1'b0;
                    d_cnt    = d_cnt + 1;
                end
            end else begin
                dmem_ack = 1'b0;
                d_cnt    = 0;
            end
        end
    end

    // Monitor: scoreboard for data accesses and retire timestamps.
    initial begin
        int   d_len = 0;
        logic d_prev = 1'b0;
        acc_t e;
        logic ok;
        forever begin
            @(negedge clk);
            #1;
            if (dmem_req) begin
                if (!d_prev) n_acc = n_acc + 1;
                d_len = d_len + 1;
                if (dmem_ack) begin
                    n_checks = n_checks + 1;
                    if (exp_q.size() == 0) begin
                        n_errors = n_errors + 1;
                        $display("FAIL dmem_access: got addr=%h we=%b wdata=%h, required no access",
                                 dmem_addr, dmem_we, dmem_wdata);
                    end else begin
                        e  = exp_q.pop_front();
                        ok = (dmem_addr == e.addr) && (dmem_we == e.we) &&
                             ((e.we == 4'd0) || (dmem_wdata == e.wdata)) &&
                             ((e.len == 0) || (d_len == e.len));
                        if (!ok) begin
                            n_errors = n_errors + 1;
                            $display("FAIL dmem_access: got addr=%h we=%b wdata=%h len=%0d, required addr=%h we=%b wdata=%h len=%0d",
                                     dmem_addr, dmem_we, dmem_wdata, d_len, e.addr, e.we, e.wdata, e.len);
                        end
                    end
                    d_len = 0;
                end
            end else begin
                d_len = 0;
            end
            d_prev = dmem_req;
            if (retire) retire_log.push_back(cyc - rel_cyc);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks = n_checks + 1;
        if (act !== req) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = 32'd0;
    endtask

    task automatic put(input int idx, input logic [31:0] word);
        imem[64 + idx] = word;
    endtask

    // Hold reset low for three edges and check the reset-state outputs.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_imem_req",   imem_req,   0);
        check("rst_imem_addr",  imem_addr,  c_reset_pc);
        check("rst_dmem_req",   dmem_req,   0);
        check("rst_halted",     halted,     0);
        check("rst_trap_cause", trap_cause, 0);
        check("rst_retire",     retire,     0);
        check("rst_cycle_cnt",  cycle_cnt,  0);
    endtask

    task automatic release_reset();
        exp_q.delete();
        retire_log.delete();
        n_acc   = 0;
        reset   = 1'b1;
        rel_cyc = cyc + 1;
    endtask

    task automatic wait_halt(input string name, input int max_cycles);
        int n = 0;
        while (!halted && n < max_cycles) begin
            @(negedge clk);
            n = n + 1;
        end
        check(name, halted, 1);
    endtask

    function automatic int log_at(input int idx);
        return (retire_log.size() > idx) ? retire_log[idx] : -1;
    endfunction

    initial begin
        logic [63:0] c_first;
        int          n;
        reset = 1'b0;
        for (int i = 0; i < 64; i++) dmem[i] = 32'd0;

        // ---- Program A: ALU chain, SW/LB/SW with 3 data wait states ----
        clear_imem();
        put(0, 32'h0050_0093);   // addi x1,x0,5
        put(1, 32'hFF90_8113);   // addi x2,x1,-7
        put(2, 32'h0020_2023);   // sw   x2,0(x0)
        put(3, 32'h0010_0183);   // lb   x3,1(x0)
        put(4, 32'h0030_2223);   // sw   x3,4(x0)
        put(5, c_ebreak);
        imem_wait = 0;
        dmem_wait = 3;
        do_reset();
        @(negedge clk);
        release_reset();
        exp_q.push_back('{32'h0, 32'hFFFF_FFFE, 4'hF, 4});
        exp_q.push_back('{32'h1, 32'h0,         4'h0, 4});
        exp_q.push_back('{32'h4, 32'hFFFF_FFFF, 4'hF, 4});
        wait_halt("a_halted", 300);
        check("a_cause",     trap_cause, 0);
        check("a_retires",   retire_log.size(), 5);
        check("a_retire0",   log_at(0), 2);
        check("a_retire1",   log_at(1), 4);
        check("a_pending",   exp_q.size(), 0);
        check("a_lb_result", dmem[1], 32'hFFFF_FFFF);
        check("a_imem_addr", imem_addr, 32'h0000_0114);

        // ---- Program B: SH/SB lanes, then misaligned LW ----
        clear_imem();
        put(0, 32'h1234_5237);   // lui  x4,0x12345
        put(1, 32'h6782_0213);   // addi x4,x4,0x678
        put(2, 32'h0040_1323);   // sh   x4,6(x0)
        put(3, 32'h0040_01A3);   // sb   x4,3(x0)
        put(4, 32'h0020_2283);   // lw   x5,2(x0)  -> misaligned
        imem_wait = 1;
        dmem_wait = 0;
        do_reset();
        @(negedge clk);
        release_reset();
        exp_q.push_back('{32'h6, 32'h5678_5678, 4'b1100, 1});
        exp_q.push_back('{32'h3, 32'h7878_7878, 4'b1000, 1});
        wait_halt("b_halted", 300);
        check("b_cause",     trap_cause, 3);
        check("b_imem_addr", imem_addr, 32'h0000_0110);
        check("b_accesses",  n_acc, 2);
        check("b_dmem_req",  dmem_req, 0);
        check("b_pending",   exp_q.size(), 0);

        // ---- Program D: JAL to a misaligned target ----
        clear_imem();
        put(0, 32'h0550_0293);   // addi x5,x0,0x55
        put(1, 32'h0060_02EF);   // jal  x5,+6
        imem_wait = 0;
        do_reset();
        @(negedge clk);
        release_reset();
        wait_halt("d_halted", 100);
        check("d_cause",     trap_cause, 2);
        check("d_imem_addr", imem_addr, 32'h0000_0104);
        check("d_rd_kept",   dut.r_rf[5], 32'h0000_0055);
        check("d_retires",   retire_log.size(), 1);

        // ---- Illegal all-zero word at the reset vector ----
        clear_imem();
        do_reset();
        @(negedge clk);
        release_reset();
        wait_halt("e_halted", 100);
        check("e_cause",     trap_cause, 1);
        check("e_imem_addr", imem_addr, c_reset_pc);
        check("e_retires",   retire_log.size(), 0);

        // ---- Reset during a stalled fetch; late ack must be ignored ----
        clear_imem();
        put(0, c_ebreak);
        manual      = 1'b1;
        manual_iack = 1'b0;
        do_reset();
        @(negedge clk);
        release_reset();
        n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n = n + 1;
        end
        repeat (2) @(negedge clk);
        check("r_req_wait",  imem_req, 1);
        check("r_addr_wait", imem_addr, c_reset_pc);
        reset = 1'b0;
        @(negedge clk);
        check("r_req_drop",  imem_req, 0);
        @(posedge clk);
        #2 manual_iack = 1'b1;     // ack (with an illegal word) arrives while in reset
        repeat (2) @(negedge clk);
        reset = 1'b1;              // ack still high across the first edge after release
        @(posedge clk);
        #2;
        manual      = 1'b0;
        manual_iack = 1'b0;
        @(negedge clk);
        #1;
        check("r_req_after",  imem_req, 1);
        check("r_addr_after", imem_addr, c_reset_pc);
        wait_halt("r_halted", 100);
        check("r_cause", trap_cause, 0);

        // ---- Program C: fetch wait states and performance counters ----
        clear_imem();
        put(0, 32'h0010_0093);   // addi x1,x0,1
        put(1, 32'h0020_0113);   // addi x2,x0,2
        put(2, 32'h0030_0193);   // addi x3,x0,3
        put(3, c_ebreak);
        imem_wait = 2;
        do_reset();
        @(negedge clk);
        release_reset();
        wait_halt("c_halted", 200);
        check("c_cause",   trap_cause, 0);
        check("c_retire0", log_at(0), 4);
        check("c_retire1", log_at(1), 8);
        c_first = cycle_cnt;
        repeat (5) @(negedge clk);
`ifdef CPU_MC_PERF_EN
        check("c_instret",     instret_cnt, 3);
        check("c_cycle_delta", cycle_cnt - c_first, 5);
`else
        check("c_instret_off", instret_cnt, 0);
        check("c_cycle_off",   cycle_cnt, 0);
        check("c_cycle_hold",  c_first, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        n_errors = n_errors + 1;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
